decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WIDTH, default 16, instruction/immediate word width in bits.
REQ-002 Parameter OPW, default 5, opcode field width.
REQ-003 Parameter RAW, default 3, register address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  in_word holds a fetched word.
REQ-007 in_word  input  WIDTH  fetched instruction or immediate word.
REQ-008 in_ready  output  1  stage accepts in_word this cycle.
REQ-009 flush  input  1  discard the partial and the held instruction.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream (execute stage) accepts the bundle.
REQ-012 opcode  output  OPW  opcode field.
REQ-013 rs1, rs2, rd  output  RAW each  source and destination register addresses.
REQ-014 imm  output  WIDTH  immediate word; 0 for one-word instructions.
REQ-015 has_imm  output  1  bundle is from a two-word instruction.
REQ-016 alu_op  output  3  ALU operation; reg_wr, mem_rd, mem_wr, alu_src  output  1 each  control bits.

Function
REQ-017 Field map: opcode=in_word[WIDTH-1 -: OPW], rs1 next RAW bits, rs2 next RAW bits, rd next RAW bits; remaining low bits are ignored.
REQ-018 Two-word class: opcode[OPW-1:OPW-2]==2'b11; the following accepted word is the immediate.
REQ-019 FSM states: S_OP (expect opcode word), S_IMM (expect immediate word).
REQ-020 S_OP + accepted one-word instruction -> load bundle, out_valid=1 next cycle, stay in S_OP; latency 1 cycle.
REQ-021 S_OP + accepted two-word instruction -> latch fields into a pending register, go to S_IMM, out_valid unchanged.
REQ-022 S_IMM + accepted word -> bundle = pending fields + imm=in_word, has_imm=1, out_valid=1 next cycle, go to S_OP.
REQ-023 Word accepted iff in_valid && in_ready; in_ready = !out_valid || out_ready, or in S_IMM with no word pending into the output register.
REQ-024 out_valid && !out_ready: all bundle outputs hold stable; no bundle is dropped or duplicated.
REQ-025 out_valid && out_ready with no new bundle: out_valid clears next cycle.
REQ-026 Control decode: alu_op=opcode[2:0]; alu_src=has_imm; mem_rd=(opcode==OP_LDD); mem_wr=(opcode==OP_STD); reg_wr=1 except OP_NOP, OP_STD, and class opcode[OPW-1:OPW-2]==2'b10 (branches).
REQ-027 flush (synchronous, priority over everything else): out_valid=0, state=S_OP, pending cleared, word presented the same cycle not accepted (in_ready=0).
REQ-028 A bundle is emitted only when out_ready backpressure permits; a two-word instruction whose immediate arrives while the output is stalled waits in S_IMM.
REQ-029 in_valid=0 in S_IMM: remain in S_IMM indefinitely.

Reset
REQ-030 rst low: state=S_OP, out_valid=0, all bundle outputs and pending register =0, asynchronously, including mid-S_IMM.
REQ-031 First acceptance is possible on the first rising edge after rst deasserts.

Structure
REQ-032 Package decode_pkg holds OPW/RAW defaults, opcode constants (OP_NOP=0, OP_LDD, OP_STD, OP_LDM, ...), class encodings, and the state enum.
REQ-033 Control decoding is one combinational sub-module decode_ctrl (opcode,has_imm -> alu_op,reg_wr,mem_rd,mem_wr,alu_src); the FSM and registers live in decode_stage.

Verification
REQ-034 One-word ADD 0x0A2C (opcode 0x01) with out_ready=1 -> next cycle out_valid=1, rs1=2, rs2=1, rd=3, has_imm=0, imm=0, reg_wr=1.
REQ-035 Two-word LDM (opcode 0x18) then 0x1234 -> one bundle with has_imm=1, imm=0x1234, alu_src=1, emitted exactly one cycle after the immediate.
REQ-036 out_ready=0 for 5 cycles with 3 words offered -> bundle held stable, in_ready=0, no loss; release -> bundles appear in order.
REQ-037 flush in S_IMM, next word 0x0A2C -> decoded as a fresh one-word instruction, not as an immediate.
REQ-038 rst asserted mid-S_IMM -> out_valid=0 immediately; after release, next word is decoded as an opcode word.
REQ-039 Back-to-back one-word instructions with out_ready=1 -> one bundle per cycle, in_ready constant 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: field-width defaults, opcode map,
// instruction class encodings and the two-state word-assembly FSM.
package decode_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int OPW_DEF   = 5;
    localparam int RAW_DEF   = 3;

    localparam logic [OPW_DEF-1:0] OP_NOP = 5'h00;
    localparam logic [OPW_DEF-1:0] OP_ADD = 5'h01;
    localparam logic [OPW_DEF-1:0] OP_LDD = 5'h08;
    localparam logic [OPW_DEF-1:0] OP_STD = 5'h09;
    localparam logic [OPW_DEF-1:0] OP_BEQ = 5'h10;
    localparam logic [OPW_DEF-1:0] OP_LDM = 5'h18;

    // Top two opcode bits select the instruction class.
    localparam logic [1:0] CLASS_BR  = 2'b10;
    localparam logic [1:0] CLASS_TWO = 2'b11;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    function automatic logic is_two_word(input logic [1:0] cls);
        return cls == CLASS_TWO;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side signals of the decode stage.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds data stable while valid && !ready, and ready may depend on valid.
interface decode_if
    import decode_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int RAW   = RAW_DEF
);
    logic             in_valid;
    logic [WIDTH-1:0] in_word;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OPW-1:0]   opcode;
    logic [RAW-1:0]   rs1;
    logic [RAW-1:0]   rs2;
    logic [RAW-1:0]   rd;
    logic [WIDTH-1:0] imm;
    logic             has_imm;
    logic [2:0]       alu_op;
    logic             reg_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic             alu_src;

    modport master (
        output in_valid, in_word, flush, out_ready,
        input  in_ready, out_valid, opcode, rs1, rs2, rd, imm, has_imm,
               alu_op, reg_wr, mem_rd, mem_wr, alu_src
    );

    modport slave (
        input  in_valid, in_word, flush, out_ready,
        output in_ready, out_valid, opcode, rs1, rs2, rd, imm, has_imm,
               alu_op, reg_wr, mem_rd, mem_wr, alu_src
    );

endinterface

// File: rtl/decode_ctrl.sv
// Combinational control-bit decode from the registered opcode of a bundle.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] opcode,
    input  logic           has_imm,
    output logic [2:0]     alu_op,
    output logic           reg_wr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           alu_src
);

    logic is_branch;

    assign is_branch = (opcode[OPW-1 -: 2] == CLASS_BR);
    assign alu_op    = opcode[2:0];
    assign alu_src   = has_imm;
    assign mem_rd    = (opcode == OPW'(OP_LDD));
    assign mem_wr    = (opcode == OPW'(OP_STD));
    assign reg_wr    = !((opcode == OPW'(OP_NOP)) || mem_wr || is_branch);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits fetched words into register fields, assembles two-word
// instructions with their immediate, and presents one bundle at a time downstream.
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int RAW   = RAW_DEF
) (
    input  logic   clk,
    input  logic   rst,
    decode_if.slave bus,
    output state_t dbg_state
);

    localparam int RS1_HI = WIDTH - OPW - 1;
    localparam int RS2_HI = RS1_HI - RAW;
    localparam int RD_HI  = RS2_HI - RAW;
    localparam int LOW_W  = WIDTH - OPW - 3 * RAW;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [RAW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             has_imm_q, has_imm_d;
    logic [OPW-1:0]   pend_opcode_q, pend_opcode_d;
    logic [RAW-1:0]   pend_rs1_q, pend_rs1_d, pend_rs2_q, pend_rs2_d, pend_rd_q, pend_rd_d;

    logic [OPW-1:0]   f_opcode;
    logic [RAW-1:0]   f_rs1, f_rs2, f_rd;
    logic             in_ready, accept, fire;

    assign f_opcode = bus.in_word[WIDTH-1 -: OPW];
    assign f_rs1    = bus.in_word[RS1_HI -: RAW];
    assign f_rs2    = bus.in_word[RS2_HI -: RAW];
    assign f_rd     = bus.in_word[RD_HI -: RAW];

    generate
        if (LOW_W > 0) begin : g_low
            logic unused_low;
            assign unused_low = ^bus.in_word[LOW_W-1:0];
        end
    endgenerate

    // Every accepted word in S_OP or S_IMM may produce a bundle, so intake
    // waits for a free (or freeing) output register regardless of state.
    assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign fire     = out_valid_q && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        opcode_d      = opcode_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        has_imm_d     = has_imm_q;
        pend_opcode_d = pend_opcode_q;
        pend_rs1_d    = pend_rs1_q;
        pend_rs2_d    = pend_rs2_q;
        pend_rd_d     = pend_rd_q;
        if (bus.flush) begin
            state_d       = S_OP;
            out_valid_d   = 1'b0;
            pend_opcode_d = '0;
            pend_rs1_d    = '0;
            pend_rs2_d    = '0;
            pend_rd_d     = '0;
        end else begin
            if (fire) out_valid_d = 1'b0;
            if (accept) begin
                if (state_q == S_IMM) begin
                    opcode_d    = pend_opcode_q;
                    rs1_d       = pend_rs1_q;
                    rs2_d       = pend_rs2_q;
                    rd_d        = pend_rd_q;
                    imm_d       = bus.in_word;
                    has_imm_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_OP;
                end else if (is_two_word(f_opcode[OPW-1 -: 2])) begin
                    pend_opcode_d = f_opcode;
                    pend_rs1_d    = f_rs1;
                    pend_rs2_d    = f_rs2;
                    pend_rd_d     = f_rd;
                    state_d       = S_IMM;
                end else begin
                    opcode_d    = f_opcode;
                    rs1_d       = f_rs1;
                    rs2_d       = f_rs2;
                    rd_d        = f_rd;
                    imm_d       = '0;
                    has_imm_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_OP;
            out_valid_q   <= 1'b0;
            opcode_q      <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            has_imm_q     <= 1'b0;
            pend_opcode_q <= '0;
            pend_rs1_q    <= '0;
            pend_rs2_q    <= '0;
            pend_rd_q     <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            opcode_q      <= opcode_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            has_imm_q     <= has_imm_d;
            pend_opcode_q <= pend_opcode_d;
            pend_rs1_q    <= pend_rs1_d;
            pend_rs2_q    <= pend_rs2_d;
            pend_rd_q     <= pend_rd_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.rd        = rd_q;
    assign bus.imm       = imm_q;
    assign bus.has_imm   = has_imm_q;
    assign dbg_state     = state_q;

    decode_ctrl #(.OPW(OPW)) u_ctrl (
        .opcode  (opcode_q),
        .has_imm (has_imm_q),
        .alu_op  (bus.alu_op),
        .reg_wr  (bus.reg_wr),
        .mem_rd  (bus.mem_rd),
        .mem_wr  (bus.mem_wr),
        .alu_src (bus.alu_src)
    );

endmodule
